fetch_stage: RTL and testbench

//  Instruction-fetch stage directly upstream of the decode pipeline register. Owns the PC,

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_skid.sv | 32 +++
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM encoding, NOP encoding, default widths.
package fetch_pkg;
  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 15;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  // All-zero word decodes as a no-op downstream.
  localparam logic [DWIDTH_DEF-1:0] NOP_INST = '0;
endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding the read that was in flight when a stall began.
module fetch_skid #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [AWIDTH-1:0] in_addr,
  input  logic [DWIDTH-1:0] in_inst,
  output logic              valid,
  output logic [AWIDTH-1:0] addr,
  output logic [DWIDTH-1:0] inst
);

  // Clear wins over load; the two are never raised together by the fetch FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      addr  <= '0;
      inst  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= in_addr;
      inst  <= in_inst;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives synchronous program memory and
// presents registered {addr, inst, valid} to decode with stall and redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                DWIDTH     = DWIDTH_DEF,
  parameter int                AWIDTH     = AWIDTH_DEF,
  parameter logic [AWIDTH-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [AWIDTH-1:0] branch_target,
  output logic [AWIDTH-1:0] pmem_addr,
  output logic              pmem_en,
  input  logic [DWIDTH-1:0] pmem_data,
  output logic [AWIDTH-1:0] fetch_addr,
  output logic [DWIDTH-1:0] fetch_inst,
  output logic              fetch_valid
);

  localparam logic [DWIDTH-1:0] NOP = DWIDTH'(NOP_INST);

  fetch_state_e      state, state_n;
  logic [AWIDTH-1:0] pc;
  logic              inflight_valid;
  logic [AWIDTH-1:0] inflight_addr;
  logic              issue, do_stall, do_branch;
  logic              skid_valid;
  logic [AWIDTH-1:0] skid_addr;
  logic [DWIDTH-1:0] skid_inst;

  assign pmem_addr = pc;
  assign pmem_en   = issue;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH_IDLE;
    else      state <= state_n;
  end

  // Next state and per-cycle action: redirect beats stall beats normal fetch.
  always_comb begin
    state_n   = state;
    issue     = 1'b0;
    do_stall  = 1'b0;
    do_branch = 1'b0;
    unique case (state)
      FETCH_IDLE: if (start) state_n = FETCH_RUN;
      FETCH_RUN, FETCH_HOLD: begin
        if (branch_taken) begin
          do_branch = 1'b1;
          state_n   = FETCH_RUN;
        end else if (stall) begin
          do_stall = 1'b1;
          state_n  = FETCH_HOLD;
        end else begin
          issue   = 1'b1;
          state_n = FETCH_RUN;
        end
      end
      default: state_n = FETCH_IDLE;
    endcase
  end

  // PC, in-flight tracking and the decode-facing output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc             <= RESET_ADDR;
      inflight_valid <= 1'b0;
      inflight_addr  <= '0;
      fetch_addr     <= '0;
      fetch_inst     <= NOP;
      fetch_valid    <= 1'b0;
    end else if (do_branch) begin
      pc             <= branch_target;
      inflight_valid <= 1'b0;
      fetch_inst     <= NOP;
      fetch_valid    <= 1'b0;
    end else if (do_stall) begin
      inflight_valid <= 1'b0;
    end else if (issue) begin
      pc             <= pc + 1'b1;
      inflight_valid <= 1'b1;
      inflight_addr  <= pc;
      if (skid_valid) begin
        fetch_addr  <= skid_addr;
        fetch_inst  <= skid_inst;
        fetch_valid <= 1'b1;
      end else begin
        fetch_addr  <= inflight_addr;
        fetch_inst  <= inflight_valid ? pmem_data : NOP;
        fetch_valid <= inflight_valid;
      end
    end
  end

  // Only the first stall cycle can see a read in flight, so the skid never overflows.
  fetch_skid #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (do_stall & inflight_valid),
    .clear   (do_branch | (issue & skid_valid)),
    .in_addr (inflight_addr),
    .in_inst (pmem_data),
    .valid   (skid_valid),
    .addr    (skid_addr),
    .inst    (skid_inst)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stalls, redirects, PC wrap, reset mid-stall.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall, branch_taken;
  logic [14:0] branch_target;
  logic [14:0] pmem_addr;
  logic        pmem_en;
  logic [31:0] pmem_data = '0;
  logic [14:0] fetch_addr;
  logic [31:0] fetch_inst;
  logic        fetch_valid;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.DWIDTH(32), .AWIDTH(15), .RESET_ADDR(15'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pmem_addr     (pmem_addr),
    .pmem_en       (pmem_en),
    .pmem_data     (pmem_data),
    .fetch_addr    (fetch_addr),
    .fetch_inst    (fetch_inst),
    .fetch_valid   (fetch_valid)
  );

  always #5 clk = ~clk;

  // Program memory: mem[i] = i + 0x100, one-cycle read latency.
  always @(posedge clk) if (pmem_en) pmem_data <= 32'h100 + 32'(pmem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Valid instruction at address a.
  task automatic chk_out(input string tag, input int a);
    chk({tag, ".valid"}, 32'(fetch_valid), 32'd1);
    chk({tag, ".addr"},  32'(fetch_addr), 32'(a));
    chk({tag, ".inst"},  fetch_inst, 32'h100 + 32'(a));
  endtask

  // Bubble: invalid with NOP.
  task automatic chk_nov(input string tag);
    chk({tag, ".valid"}, 32'(fetch_valid), 32'd0);
    chk({tag, ".inst"},  fetch_inst, 32'd0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    tick();
    chk("rst.valid", 32'(fetch_valid), 32'd0);
    chk("rst.addr",  32'(fetch_addr), 32'd0);
    chk("rst.inst",  fetch_inst, 32'd0);
    chk("rst.en",    32'(pmem_en), 32'd0);
    chk("rst.pc",    32'(pmem_addr), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle.en", 32'(pmem_en), 32'd0);

    // 1: streaming from reset
    start = 1'b1;
    tick();
    chk("t1.en", 32'(pmem_en), 32'd1);
    chk("t1.pc", 32'(pmem_addr), 32'd0);
    chk_nov("t1.c1");
    start = 1'b0;
    tick();
    chk_nov("t1.c2");
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_out("t1.stream", k);
    end

    // 2: one-cycle stall then three-cycle stall
    stall = 1'b1;
    #1 chk("t2.en_stall", 32'(pmem_en), 32'd0);
    tick();
    chk_out("t2.hold1", 7);
    stall = 1'b0;
    tick(); chk_out("t2.rel1", 8);
    tick(); chk_out("t2.s1", 9);
    tick(); chk_out("t2.s2", 10);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("t2.hold3", 10);
      chk("t2.hold3.en", 32'(pmem_en), 32'd0);
    end
    stall = 1'b0;
    tick(); chk_out("t2.rel3", 11);
    chk("t2.rel3.en", 32'(pmem_en), 32'd1);
    tick(); chk_out("t2.s3", 12);
    tick(); chk_out("t2.s4", 13);

    // 3: redirect to 0x40, then redirect with concurrent stall
    branch_taken = 1'b1; branch_target = 15'h40;
    #1 chk("t3.en_br", 32'(pmem_en), 32'd0);
    tick(); chk_nov("t3.b1");
    branch_taken = 1'b0;
    tick(); chk_nov("t3.b2");
    chk("t3.pc", 32'(pmem_addr), 32'h41);
    tick(); chk_out("t3.tgt0", 'h40);
    tick(); chk_out("t3.tgt1", 'h41);
    tick(); chk_out("t3.tgt2", 'h42);
    branch_taken = 1'b1; stall = 1'b1; branch_target = 15'h40;
    tick(); chk_nov("t3s.b1");
    branch_taken = 1'b0; stall = 1'b0;
    tick(); chk_nov("t3s.b2");
    tick(); chk_out("t3s.tgt0", 'h40);
    tick(); chk_out("t3s.tgt1", 'h41);

    // 4: PC wrap at 0x7FFF
    branch_taken = 1'b1; branch_target = 15'h7FFE;
    tick(); chk_nov("t4.b1");
    branch_taken = 1'b0;
    tick(); chk_nov("t4.b2");
    tick(); chk_out("t4.a", 'h7FFE);
    tick(); chk_out("t4.b", 'h7FFF);
    tick(); chk_out("t4.wrap", 0);
    tick(); chk_out("t4.after", 1);

    // 5: async reset during stall with skid full, then IDLE ignores stall/branch
    stall = 1'b1;
    tick(); chk_out("t5.hold", 1);
    rst = 1'b0;
    #1;
    chk("t5.rst.valid", 32'(fetch_valid), 32'd0);
    chk("t5.rst.addr",  32'(fetch_addr), 32'd0);
    chk("t5.rst.inst",  fetch_inst, 32'd0);
    chk("t5.rst.en",    32'(pmem_en), 32'd0);
    chk("t5.rst.pc",    32'(pmem_addr), 32'd0);
    tick();
    rst = 1'b1; branch_taken = 1'b1; branch_target = 15'h40;
    tick();
    chk("t5.idle.en", 32'(pmem_en), 32'd0);
    chk("t5.idle.pc", 32'(pmem_addr), 32'd0);
    chk_nov("t5.idle");
    tick();
    chk("t5.idle2.pc", 32'(pmem_addr), 32'd0);
    chk_nov("t5.idle2");
    stall = 1'b0; branch_taken = 1'b0; start = 1'b1;
    tick();
    chk("t5.start.en", 32'(pmem_en), 32'd1);
    chk("t5.start.pc", 32'(pmem_addr), 32'd0);
    chk_nov("t5.c1");
    start = 1'b0;
    tick(); chk_nov("t5.c2");
    tick(); chk_out("t5.s0", 0);
    tick(); chk_out("t5.s1", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
